// File: rtl/rf_pkg.sv
// Shared register-file types and the default geometry used by the core.
package rf_pkg;

  localparam int unsigned RF_WIDTH    = 32;
  localparam int unsigned RF_DEPTH    = 32;
  localparam int unsigned RF_ZERO_REG = 1;
  localparam int unsigned RF_AW       = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]    rf_idx_t;
  typedef logic [RF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending write so issue logic can detect RAW hazards.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = RF_ZERO_REG,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_idx,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_idx,
  input  logic [NUM_WR-1:0]             wr_clr,
  input  logic                          rsv_en,
  input  logic [AW-1:0]                 rsv_idx,
  input  logic                          flush
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] clr_vec;

  // Clears applied first so a same-cycle reservation overrides them; flush overrides everything.
  always_comb begin
    clr_vec = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_clr[w]) clr_vec[wr_idx[w]] = 1'b1;
    end
    busy_nxt = busy & ~clr_vec;
    if (rsv_en) busy_nxt[rsv_idx] = 1'b1;
    if (flush) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // A clearing write retires the hazard in the same cycle its data is bypassed.
  always_comb begin
    rd_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_busy[r] = busy[rd_idx[r]] & ~clr_vec[rd_idx[r]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, optional zero register and busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = RF_ZERO_REG,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_idx,
  output logic [NUM_RD-1:0][WIDTH-1:0]  rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_idx,
  input  logic [NUM_WR-1:0][WIDTH-1:0]  wr_data,
  input  logic [NUM_WR-1:0]             wr_clr,
  input  logic                          rsv_en,
  input  logic [AW-1:0]                 rsv_idx,
  input  logic                          flush
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Ascending port order: the last non-blocking write wins, giving the highest port priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && !(ZERO_REG != 0 && wr_idx[w] == '0)) mem[wr_idx[w]] <= wr_data[w];
      end
    end
  end

  // Outputs are forced to zero while reset is held, even against an in-flight write bypass.
  always_comb begin
    rd_data = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_data[r] = mem[rd_idx[r]];
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_idx[w] == rd_idx[r]) rd_data[r] = wr_data[w];
      end
      if (!rst || (ZERO_REG != 0 && rd_idx[r] == '0)) rd_data[r] = '0;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rd_idx),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_clr  (wr_clr),
    .rsv_en  (rsv_en),
    .rsv_idx (rsv_idx),
    .flush   (flush)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read / 2 write ports) against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned W = 32;
  localparam int unsigned D = 32;
  localparam int unsigned A = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0][A-1:0]   rd_idx;
  logic [1:0][W-1:0]   rd_data;
  logic [1:0]          rd_busy;
  logic [1:0]          wr_en;
  logic [1:0][A-1:0]   wr_idx;
  logic [1:0][W-1:0]   wr_data;
  logic [1:0]          wr_clr;
  logic                rsv_en;
  logic [A-1:0]        rsv_idx;
  logic                flush;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem_m [D];
  bit           busy_m [D];

  regfile_mp #(
    .WIDTH    (W),
    .DEPTH    (D),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_clr  (wr_clr),
    .rsv_en  (rsv_en),
    .rsv_idx (rsv_idx),
    .flush   (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    for (int i = 0; i < int'(D); i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
  endfunction

  // Architectural effect of one clock edge, from the current input values.
  function automatic void model_edge();
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_idx[w] != 0) mem_m[wr_idx[w]] = wr_data[w];
    if (flush) begin
      for (int i = 0; i < int'(D); i++) busy_m[i] = 1'b0;
    end else begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_clr[w]) busy_m[wr_idx[w]] = 1'b0;
      if (rsv_en && rsv_idx != 0) busy_m[rsv_idx] = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] exp_data(input int r);
    logic [W-1:0] v;
    if (!rst || rd_idx[r] == 0) return '0;
    v = mem_m[rd_idx[r]];
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_idx[w] == rd_idx[r]) v = wr_data[w];
    return v;
  endfunction

  function automatic logic exp_busy(input int r);
    logic b;
    if (!rst) return 1'b0;
    b = busy_m[rd_idx[r]];
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_clr[w] && wr_idx[w] == rd_idx[r]) b = 1'b0;
    return b;
  endfunction

  task automatic idle();
    wr_en = '0; wr_clr = '0; wr_idx = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_idx = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rd_idx = '{5'd5, 5'd5};
    #2 rst = 1'b0;
    model_reset();
    wr_en[0] = 1'b1; wr_idx[0] = 5'd5; wr_data[0] = 32'hCAFE_F00D;
    step();
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (rd_data[r] !== 32'h0) begin
        errors++; $display("FAIL reset_data[%0d]: got %h want 0", r, rd_data[r]);
      end
      checks++;
      if (rd_busy[r] !== 1'b0) begin
        errors++; $display("FAIL reset_busy[%0d]: got %b want 0", r, rd_busy[r]);
      end
    end
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data[0] !== 32'h0) begin
      errors++; $display("FAIL reset_write_dropped: got %h want 0", rd_data[0]);
    end
    wr_en[0] = 1'b1; wr_idx[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    step();
    idle();
    #1;
    checks++;
    if (rd_data[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_release_write: got %h want deadbeef", rd_data[0]);
    end
  endtask

  task automatic test_write_through();
    idle();
    rd_idx[0] = 5'd7;
    wr_en[0] = 1'b1; wr_idx[0] = 5'd7; wr_data[0] = 32'h1234;
    #1;
    checks++;
    if (rd_data[0] !== 32'h1234) begin
      errors++; $display("FAIL bypass: got %h want 1234", rd_data[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data[0] !== 32'h1234) begin
      errors++; $display("FAIL bypass_stored: got %h want 1234", rd_data[0]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    rd_idx = '{5'd0, 5'd0};
    wr_en[1] = 1'b1; wr_idx[1] = 5'd0; wr_data[1] = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_idx = 5'd0;
    #1;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (rd_data[r] !== 32'h0) begin
        errors++; $display("FAIL zero_bypass[%0d]: got %h want 0", r, rd_data[r]);
      end
    end
    step();
    idle();
    #1;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (rd_data[r] !== 32'h0 || rd_busy[r] !== 1'b0) begin
        errors++; $display("FAIL zero_stored[%0d]: got %h/%b want 0/0", r, rd_data[r], rd_busy[r]);
      end
    end
  endtask

  task automatic test_collision();
    idle();
    rd_idx = '{5'd3, 5'd3};
    wr_en = 2'b11; wr_idx = '{5'd3, 5'd3};
    wr_data[0] = 32'hAAAA; wr_data[1] = 32'hBBBB;
    #1;
    checks++;
    if (rd_data[0] !== 32'hBBBB) begin
      errors++; $display("FAIL collision_bypass: got %h want bbbb", rd_data[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_data[1] !== 32'hBBBB) begin
      errors++; $display("FAIL collision_stored: got %h want bbbb", rd_data[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rd_idx = '{5'd1, 5'd9};
    rsv_en = 1'b1; rsv_idx = 5'd9;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL rsv_same_cycle: got %b want 0", rd_busy[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL rsv_busy: got %b want 1", rd_busy[0]);
    end
    wr_en[0] = 1'b1; wr_clr[0] = 1'b1; wr_idx[0] = 5'd9; wr_data[0] = 32'h55;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h55) begin
      errors++; $display("FAIL clr_bypass: got %b/%h want 0/55", rd_busy[0], rd_data[0]);
    end
    step();
    idle();
    rsv_en = 1'b1; rsv_idx = 5'd9;
    step();
    wr_en[1] = 1'b1; wr_clr[1] = 1'b1; wr_idx[1] = 5'd9; wr_data[1] = 32'h66;
    step();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL rsv_beats_clr: got %b want 1", rd_busy[0]);
    end
  endtask

  task automatic test_flush();
    idle();
    rsv_en = 1'b1; rsv_idx = 5'd4;
    step();
    rsv_idx = 5'd12;
    step();
    idle();
    rd_idx = '{5'd12, 5'd4};
    #1;
    checks++;
    if (rd_busy !== 2'b11) begin
      errors++; $display("FAIL pre_flush_busy: got %b want 11", rd_busy);
    end
    flush = 1'b1; rsv_en = 1'b1; rsv_idx = 5'd6;
    step();
    idle();
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++; $display("FAIL flush_busy: got %b want 00", rd_busy);
    end
    checks++;
    if (rd_data[0] !== exp_data(0)) begin
      errors++; $display("FAIL flush_data: got %h want %h", rd_data[0], exp_data(0));
    end
    rd_idx[0] = 5'd6;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++; $display("FAIL flush_rsv_ignored: got %b want 0", rd_busy[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_clr[w]  = $urandom_range(0, 1) == 1;
        wr_idx[w]  = A'($urandom_range(0, 15));
        wr_data[w] = $urandom;
      end
      for (int r = 0; r < 2; r++) rd_idx[r] = A'($urandom_range(0, 15));
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_idx = A'($urandom_range(0, 15));
      flush   = ($urandom_range(0, 29) == 0);
      // Occasional asynchronous reset pulse between edges.
      if (n == 200) begin
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
      end
      #1;
      for (int r = 0; r < 2; r++) begin
        checks++;
        if (rd_data[r] !== exp_data(r)) begin
          errors++; $display("FAIL rand_data[%0d] n=%0d idx=%0d: got %h want %h", r, n, rd_idx[r], rd_data[r], exp_data(r));
        end
        checks++;
        if (rd_busy[r] !== exp_busy(r)) begin
          errors++; $display("FAIL rand_busy[%0d] n=%0d idx=%0d: got %b want %b", r, n, rd_idx[r], rd_busy[r], exp_busy(r));
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    rd_idx = '0;
    model_reset();
    test_reset();
    test_write_through();
    test_zero_reg();
    test_collision();
    test_scoreboard();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
